mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS datapath. It sits directly upstream of the unified instruction/data memory.
- Drives the memory write enable (memwrite) and the address-select mux (iord). Also drives the IR/PC/register-file enables and the ALU operand/function selects.
- Moore FSM sequences each instruction over 3-5 cycles.
- Embedded ALU decoder and branch-qualified PC enable.

Parameters:
- STATE_W, 4, width of state register (12 states used, codes 0-11)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  6  instruction[31:26] from IR
- funct  input  6  instruction[5:0] from IR
- zero  input  1  ALU zero flag
- memwrite  output  1  memory write enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- irwrite  output  1  IR load enable
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- regwrite  output  1  register-file write enable
- regdst  output  1  0=rt, 1=rd
- memtoreg  output  1  0=ALUOut, 1=data register
- alusrca  output  1  0=PC, 1=A
- alusrcb  output  2  00=B, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU operation
- state  output  STATE_W  current state (debug)

Behaviour:
- State register updates on rising clk. Reset is asynchronous: state <= FETCH (0) immediately on reset rising.
- While reset=1: memwrite, irwrite, pcen and regwrite are forced 0; other outputs take FETCH values.
- All outputs are combinational from state, except:
  - alucontrol also depends on funct.
  - pcen also depends on zero.
- Every signal not listed for a state is 0.
- States, asserted outputs, and next state:
  - FETCH(0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00 -> DECODE.
  - DECODE(1): alusrcb=11, aluop=00. Next state by op:
    - 100011 lw -> MEMADR
    - 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other op -> FETCH (illegal op skipped, no side effects)
  - MEMADR(2): alusrca=1, alusrcb=10 -> MEMRD if op=lw, MEMWR if op=sw.
  - MEMRD(3): iord=1 -> MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0 -> FETCH.
  - MEMWR(5): iord=1, memwrite=1 -> FETCH.
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB(7): regwrite=1, regdst=1 -> FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10 -> ADDIWB.
  - ADDIWB(10): regwrite=1, regdst=0 -> FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1 -> FETCH.
  - Unused codes 12-15 -> FETCH, all enables 0.
- Instruction latency in cycles, FETCH inclusive: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- ALU decoder:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 10 decodes funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> 010
- memwrite is asserted only in MEMWR. At most one of memwrite/irwrite is high in any cycle.
- Reset asserted mid-instruction (e.g. in MEMWR): memwrite drops to 0 combinationally in the same cycle. After reset deasserts, the FSM resumes at FETCH on the next rising edge.

Test Plan:
- Reset high 2 cycles, then release -> state=0. During reset memwrite=irwrite=pcen=regwrite=0. First post-reset cycle: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0. In state 3: iord=1, memwrite=0. In state 4: regwrite=1, memtoreg=1, regdst=0.
- op=101011 (sw) -> state sequence 0,1,2,5,0. In state 5: memwrite=1, iord=1, regwrite=0.
- op=000000 with funct=101010 -> in state 6, alucontrol=111. In state 7, regwrite=1, regdst=1.
- op=000100 (beq), zero=1 -> in state 8, pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 -> pcen=0.
- op=111111 (illegal) -> state sequence 0,1,0, no write enables after FETCH. Separately, assert reset while in state 5 -> memwrite=0 the same cycle, state=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with ALU decoder
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, forces state to FETCH
//   op         instruction[31:26] from IR
//   funct      instruction[5:0] from IR
//   zero       ALU zero flag, qualifies the branch PC enable
//   memwrite   memory write enable (MEMWR only)
//   iord       memory address select: 0=PC, 1=ALUOut
//   irwrite    IR load enable
//   pcen       PC load enable = pcwrite | (branch & zero)
//   regwrite   register-file write enable
//   regdst     write register select: 0=rt, 1=rd
//   memtoreg   write data select: 0=ALUOut, 1=data register
//   alusrca    ALU A select: 0=PC, 1=A
//   alusrcb    ALU B select: 00=B, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc      next PC select: 00=ALUResult, 01=ALUOut, 10=jump target
//   alucontrol ALU operation
//   state      current state (debug)
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               pcen,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur, nxt;
  logic       mw_raw, irw_raw, rw_raw, pcwrite, branch;
  logic [1:0] aluop;

  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt      = FETCH;
    mw_raw   = 1'b0;
    irw_raw  = 1'b0;
    rw_raw   = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (cur)
      FETCH: begin
        irw_raw = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        nxt     = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = FETCH;  // illegal op: back to fetch with no side effects
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      nxt = MEMRD;
        else if (op == OP_SW) nxt = MEMWR;
        else                  nxt = FETCH;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        rw_raw   = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mw_raw = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        rw_raw = 1'b1;
        regdst = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        rw_raw = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Write enables are masked by reset itself so they fall in the same cycle
  // reset rises, independent of the state register settling.
  assign memwrite = mw_raw & ~reset;
  assign irwrite  = irw_raw & ~reset;
  assign regwrite = rw_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule
